// File: rtl/sdram_port.sv
// CPU-to-SDRAM bridge: posted-write FIFO with store-to-load forwarding in front
// of a simple level/handshake SDRAM controller port.
module sdram_port #(
    parameter logic [15:0] BASE  = 16'h4C00,
    parameter int          DEPTH = 2
) (
    input  logic        clki,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_ready,
    output logic [23:0] sd_addr,
    output logic [15:0] sd_wdata,
    input  logic [15:0] sd_rdata,
    output logic        sd_read,
    output logic        sd_write,
    input  logic        sd_busy,
    input  logic        sd_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_t;

    state_t state, state_n;

    logic [15:0]   fifo_addr [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [AW-1:0] head, tail, idx;
    logic [AW:0]   count;
    logic          full, empty, pop, wr_ok, hit, fwd, rd_done;
    logic [15:0]   hit_data;
    logic          sd_read_n, sd_write_n;
    logic [23:0]   sd_addr_n;
    logic [15:0]   sd_wdata_n;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == WR_WAIT) && sd_ready;
    // A pop in the same cycle frees the slot the incoming write needs.
    assign wr_ok = cpu_wr && !cpu_ready && (!full || pop);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (((AW+1)'(i) < count) && (fifo_addr[idx] == cpu_addr)) begin
                hit      = 1'b1;
                hit_data = fifo_data[idx];
            end
        end
    end

    assign fwd      = cpu_rd && !cpu_ready && hit;
    assign cpu_busy = (cpu_wr && !wr_ok) || (cpu_rd && !cpu_ready);

    always_comb begin
        state_n    = state;
        sd_read_n  = sd_read;
        sd_write_n = sd_write;
        sd_addr_n  = sd_addr;
        sd_wdata_n = sd_wdata;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                // Writes drain first so a read never overtakes an older write.
                if (!empty) begin
                    state_n    = WR_ISSUE;
                    sd_write_n = 1'b1;
                    sd_addr_n  = {8'h00, fifo_addr[head] - BASE};
                    sd_wdata_n = fifo_data[head];
                end else if (cpu_rd && !cpu_ready) begin
                    state_n   = RD_ISSUE;
                    sd_read_n = 1'b1;
                    sd_addr_n = {8'h00, cpu_addr - BASE};
                end
            end
            WR_ISSUE: if (sd_busy) begin
                state_n    = WR_WAIT;
                sd_write_n = 1'b0;
            end
            WR_WAIT:  if (sd_ready) state_n = IDLE;
            RD_ISSUE: if (sd_busy) begin
                state_n   = RD_WAIT;
                sd_read_n = 1'b0;
            end
            RD_WAIT: if (sd_ready) begin
                state_n = IDLE;
                rd_done = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            sd_read   <= 1'b0;
            sd_write  <= 1'b0;
            sd_addr   <= '0;
            sd_wdata  <= '0;
        end else begin
            state     <= state_n;
            sd_read   <= sd_read_n;
            sd_write  <= sd_write_n;
            sd_addr   <= sd_addr_n;
            sd_wdata  <= sd_wdata_n;
            if (wr_ok) tail <= tail + 1'b1;
            if (pop)   head <= head + 1'b1;
            count     <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
            cpu_ready <= wr_ok || fwd || rd_done;
            if (fwd)          cpu_rdata <= hit_data;
            else if (rd_done) cpu_rdata <= sd_rdata;
        end
    end

    // Storage needs no reset: validity is tracked by head/count.
    always_ff @(posedge clki) begin
        if (wr_ok) begin
            fifo_addr[tail] <= cpu_addr;
            fifo_data[tail] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_sdram_port.sv
// Directed bench for sdram_port: CPU-side stimulus plus a behavioural SDRAM
// controller; writes and reads are checked against scoreboard queues.
module tb_sdram_port;
    localparam logic [15:0] BASE_A = 16'h4C00;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clki, rst_n;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, sd_wdata, sd_rdata;
    logic        cpu_rd, cpu_wr, cpu_busy, cpu_ready;
    logic [23:0] sd_addr;
    logic        sd_read, sd_write, sd_busy, sd_ready;

    sdram_port #(.BASE(BASE_A), .DEPTH(2)) dut (
        .clki(clki), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_ready(cpu_ready),
        .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_rdata(sd_rdata),
        .sd_read(sd_read), .sd_write(sd_write), .sd_busy(sd_busy), .sd_ready(sd_ready)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    int n_cmp = 0, n_err = 0, n_wr_issue = 0, n_rd_issue = 0;
    wr_t wq[$];
    logic [15:0] rq[$];
    logic        ctl_stuck = 1'b0, ctl_hold = 1'b0, ctl_active = 1'b0;
    int          ctl_lat = 0;
    logic [15:0] ctl_rdata = '0;
    logic [23:0] exp_rd_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Controller model: accepts after ctl_lat cycles, completes when not held.
    initial begin : ctl
        wr_t e;
        sd_busy = 1'b0; sd_ready = 1'b0; sd_rdata = '0;
        forever begin
            @(negedge clki);
            sd_busy = ctl_stuck;
            if (rst_n && (sd_write || sd_read)) begin
                ctl_active = 1'b1;
                chk("cmd_exclusive", 32'(sd_write && sd_read), 0);
                if (sd_write) begin
                    n_wr_issue++;
                    chk("wr_expected", 32'(wq.size() != 0), 1);
                    if (wq.size() != 0) begin
                        e = wq.pop_front();
                        chk("wr_addr", 32'(sd_addr), 32'(e.addr));
                        chk("wr_data", 32'(sd_wdata), 32'(e.data));
                    end
                end else begin
                    n_rd_issue++;
                    chk("rd_addr", 32'(sd_addr), 32'(exp_rd_addr));
                    chk("rd_after_drain", 32'(wq.size()), 0);
                end
                repeat (ctl_lat) begin
                    @(negedge clki);
                    chk("cmd_held", 32'(sd_write || sd_read), 1);
                end
                sd_busy = 1'b1;
                @(negedge clki);
                if (!ctl_stuck) sd_busy = 1'b0;
                chk("cmd_dropped", 32'(sd_write || sd_read), 0);
                while (ctl_hold && rst_n) @(negedge clki);
                if (rst_n) begin
                    sd_rdata = ctl_rdata;
                    sd_ready = 1'b1;
                    @(negedge clki);
                    sd_ready = 1'b0;
                end
                ctl_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clki); #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input int rel,
                             output int lat, output logic b0);
        wr_t e;
        e.addr = {8'h00, 16'(a - BASE_A)};
        e.data = d;
        wq.push_back(e);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        #1 b0 = cpu_busy;
        lat = 0;
        forever begin
            tick();
            lat++;
            if (rel != 0 && lat == rel) ctl_hold = 1'b0;
            if (cpu_ready) break;
            if (lat >= 100) begin chk("wr_timeout", 32'(lat), 0); break; end
        end
        cpu_wr = 1'b0;
        tick();
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [15:0] exp,
                            output int lat, output logic b0);
        logic [15:0] x;
        rq.push_back(exp);
        cpu_addr = a; cpu_rd = 1'b1;
        #1 b0 = cpu_busy;
        lat = 0;
        forever begin
            tick();
            lat++;
            if (cpu_ready) break;
            if (lat >= 100) begin chk("rd_timeout", 32'(lat), 0); break; end
        end
        x = rq.pop_front();
        chk("rd_data", 32'(cpu_rdata), 32'(x));
        cpu_rd = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wq.size() != 0 || ctl_active || sd_write || sd_read) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 1);
        tick(); tick();
    endtask

    initial begin : stim
        int   lat, base_wr, base_rd, seen;
        logic b0;
        rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        #12;
        chk("rst_outputs", {cpu_rdata, 8'(sd_addr), 5'd0, cpu_ready, sd_read, sd_write}, 0);
        chk("rst_busy", 32'(cpu_busy), 0);
        tick(); rst_n = 1'b1; tick();

        // Basic posted write, controller accepts after 2 cycles.
        ctl_lat = 2; base_wr = n_wr_issue;
        cpu_write(16'h4C05, 16'hBEEF, 0, lat, b0);
        chk("wr_lat", 32'(lat), 1);
        chk("wr_busy0", 32'(b0), 0);
        wait_idle();
        chk("wr_bursts", 32'(n_wr_issue - base_wr), 1);

        // FIFO full with sd_busy stuck high; third write stalls until a pop.
        ctl_lat = 0; ctl_stuck = 1'b1; ctl_hold = 1'b1;
        cpu_write(16'h4C20, 16'h1111, 0, lat, b0);
        chk("full_w1_lat", 32'(lat), 1);
        cpu_write(16'h4C21, 16'h2222, 0, lat, b0);
        chk("full_w2_lat", 32'(lat), 1);
        cpu_write(16'h0003, 16'h3333, 3, lat, b0);
        chk("full_w3_busy", 32'(b0), 1);
        chk("full_w3_lat", 32'(lat), 4);
        wait_idle();
        ctl_stuck = 1'b0;
        tick(); tick();

        // Read hits a queued write: forwarded, no SDRAM read.
        ctl_hold = 1'b1; base_rd = n_rd_issue;
        cpu_write(16'h5000, 16'h1234, 0, lat, b0);
        cpu_read(16'h5000, 16'h1234, lat, b0);
        chk("fwd_lat", 32'(lat), 1);
        chk("fwd_busy0", 32'(b0), 1);
        ctl_hold = 1'b0;
        wait_idle();
        chk("fwd_no_sd_read", 32'(n_rd_issue - base_rd), 0);

        // Two queued writes to the same address: youngest data forwarded.
        ctl_hold = 1'b1;
        cpu_write(16'h5002, 16'hAAAA, 0, lat, b0);
        cpu_write(16'h5002, 16'hBBBB, 0, lat, b0);
        cpu_read(16'h5002, 16'hBBBB, lat, b0);
        chk("young_lat", 32'(lat), 1);
        ctl_hold = 1'b0;
        wait_idle();

        // Read miss behind a queued write: write drains first.
        ctl_lat = 1; base_rd = n_rd_issue;
        exp_rd_addr = 24'h001400; ctl_rdata = 16'hA5A5;
        cpu_write(16'h5000, 16'h7777, 0, lat, b0);
        cpu_read(16'h6000, 16'hA5A5, lat, b0);
        chk("miss_waited", 32'(lat > 2), 1);
        wait_idle();
        chk("miss_sd_reads", 32'(n_rd_issue - base_rd), 1);

        // Address below BASE wraps.
        ctl_lat = 0; exp_rd_addr = 24'h00B400; ctl_rdata = 16'h0F0F;
        cpu_read(16'h0000, 16'h0F0F, lat, b0);
        wait_idle();

        // Reset while the controller holds a write in its wait phase.
        ctl_hold = 1'b1;
        cpu_write(16'h4C10, 16'hCAFE, 0, lat, b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {cpu_rdata, 8'(sd_addr), 5'd0, cpu_ready, sd_read, sd_write}, 0);
        chk("midrst_sd_addr", 32'(sd_addr), 0);
        chk("midrst_sd_wdata", 32'(sd_wdata), 0);
        chk("midrst_busy", 32'(cpu_busy), 0);
        tick(); tick();
        rst_n = 1'b1; ctl_hold = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (cpu_ready || sd_write || sd_read) seen++;
        end
        chk("post_rst_quiet", 32'(seen), 0);
        base_wr = n_wr_issue;
        cpu_write(16'h4C11, 16'h0042, 0, lat, b0);
        chk("post_rst_wr_lat", 32'(lat), 1);
        wait_idle();
        chk("post_rst_bursts", 32'(n_wr_issue - base_wr), 1);

        chk("wq_empty", 32'(wq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/sdram_port.md
SDRAM_PORT -- requirements
Module: sdram_port

Interface
REQ-001 SHALL have parameter BASE, default 16'h4C00, the CPU address mapped to SDRAM word 0.
REQ-002 SHALL have parameter DEPTH, default 2, the posted-write FIFO depth (power of two, 2..8).
REQ-003 SHALL have port clki  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cpu_addr  input  16  CPU word address, valid while cpu_rd or cpu_wr is high.
REQ-006 SHALL have port cpu_wdata  input  16  write data.
REQ-007 SHALL have port cpu_rd / cpu_wr  input  1 each  level requests, held until completed; both high together is illegal.
REQ-008 SHALL have port cpu_rdata  output  16  read data, valid while cpu_ready pulses for a read.
REQ-009 SHALL have port cpu_busy  output  1  request not yet completed; CPU must hold its request.
REQ-010 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sd_addr  output  24  SDRAM word address.
REQ-012 SHALL have port sd_wdata / sd_rdata  output / input  16 each  SDRAM write and read data.
REQ-013 SHALL have port sd_read / sd_write  output  1 each  SDRAM command levels.
REQ-014 SHALL have port sd_busy / sd_ready  input  1 each  controller accept/busy and one-cycle done pulse.

Function
REQ-015 SHALL compute sd_addr = {8'h00, cpu_addr - BASE}, mod 2^16, wrapping with no range check.
REQ-016 SHALL accept a write in the first cycle where cpu_wr=1 and the FIFO is not full, push {addr, data}, and pulse cpu_ready in the next cycle; cpu_busy=0 for an accepted write.
REQ-017 SHALL hold cpu_busy=1 while cpu_wr=1 and the FIFO is full, accepting the write when a slot frees.
REQ-018 SHALL accept at most one CPU request per cpu_ready; it ignores a request in the cycle cpu_ready is high.
REQ-019 SHALL use state machine IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
REQ-020 In IDLE, SHALL go to WR_ISSUE if the FIFO is not empty, otherwise to RD_ISSUE if a read is pending and not forwarded.
REQ-021 In WR_ISSUE, SHALL drive sd_write=1 with the head entry until sd_busy=1, then go to WR_WAIT with sd_write=0.
REQ-022 In WR_WAIT, on sd_ready=1 SHALL pop the head and return to IDLE.
REQ-023 RD_ISSUE/RD_WAIT SHALL mirror write issue/wait using sd_read; on sd_ready it SHALL register sd_rdata to cpu_rdata and pulse cpu_ready for one cycle.
REQ-024 Reads SHALL wait until the FIFO has fully drained, so that reads stay ordered after earlier writes.
REQ-025 If a read address matches a FIFO entry, SHALL forward the youngest matching entry's data with cpu_ready 1 cycle after cpu_rd, with no SDRAM access.
REQ-026 SHALL keep cpu_busy=1 from read acceptance until its cpu_ready cycle.
REQ-027 SHALL treat a write arriving while a drain is in progress as a normal push; a simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-028 SHALL register all outputs except cpu_busy, which may be combinational from registered state and the CPU request inputs.

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, clear the FIFO, and drive cpu_rdata=0, cpu_ready=0, sd_read=0, sd_write=0, sd_addr=0, sd_wdata=0; cpu_busy=0 if no request is present.
REQ-030 SHALL abandon any in-flight SDRAM command on reset with no completion pulse; it SHALL issue no command before the first clki edge after rst_n rises.

Verification
REQ-031 Write 0x4C05 data 0xBEEF, controller accepts after 2 cycles -> sd_addr=0x000005, sd_wdata=0xBEEF, one sd_write burst, cpu_ready 1 cycle after cpu_wr.
REQ-032 Three back-to-back writes with sd_busy stuck high (DEPTH=2) -> third write sees cpu_busy=1 until first pop, no entry lost, SDRAM order preserved.
REQ-033 Write 0x5000=0x1234 queued then read 0x5000 -> cpu_rdata=0x1234 one cycle after cpu_rd, sd_read never asserted.
REQ-034 Write 0x5000, then read 0x6000 with sd_rdata=0xA5A5 -> sd_write completes before sd_read rises; cpu_rdata=0xA5A5 on the cpu_ready pulse.
REQ-035 Address 0x0000 read -> sd_addr=0x00B400 (wrap).
REQ-036 rst_n low during WR_WAIT -> all outputs at reset values, FIFO empty, no cpu_ready pulse, clean IDLE after release.
